uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
//  Bit-level UART receiver (8N1, LSB first); upstream stage of the hex-digit input manager.
//  Synchronises the raw RsRx pin, detects the start bit and samples each bit at mid-bit.
//  Delivers one byte per frame with a single-cycle ready strobe; the manager converts the byte to hex.
// PARAMETERS
//  CLOCK_RATE  100_000_000  clk frequency, Hz
//  BAUD_RATE   9600         line rate, bit/s
//  DATA_BITS   8            data bits per frame, 5..8
//  Derived: CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE (integer divide, must be >= 4).
//  Derived: HALF_BIT = CLKS_PER_BIT/2. Counter width = $clog2(CLKS_PER_BIT).
// PORTS
//  clk         in   1          system clock; all logic on posedge
//  reset       in   1          asynchronous, active-low reset (0 = reset)
//  rx          in   1          raw serial line, idle high, asynchronous to clk
//  data_out    out  DATA_BITS  last good byte; updated only on a good frame
//  ready_out   out  1          1-cycle pulse: data_out holds a new byte
//  frame_err   out  1          1-cycle pulse: stop bit sampled low
//  parity_err  out  1          1-cycle pulse: parity mismatch (tied 0 without the macro)
// BEHAVIOUR
//  Reset: sync FFs = 1, state = IDLE, counters = 0, data_out = 0; all pulse outputs = 0.
//  Input path: 2-FF synchroniser, rx -> rx_s. All decisions use rx_s only.
//  Bit timing: counter runs 0..CLKS_PER_BIT-1, then wraps to 0 and produces a sample tick.
//  FSM states:
//   IDLE      rx_s==0 -> START, clear counter.
//   START     at count HALF_BIT-1: rx_s==0 -> DATA (counter cleared, bit index 0); else -> IDLE (glitch).
//   DATA      each tick: shift rx_s into MSB of shift register, bit index +1.
//             After DATA_BITS bits -> STOP, or PARITY when the macro is defined.
//   PARITY    on tick: compare rx_s to the even parity of the data bits -> STOP.
//   STOP      on tick:
//             rx_s==1 -> load data_out and pulse ready_out in the next cycle. State -> IDLE.
//               Also pulse parity_err when a mismatch was recorded; data_out is still loaded.
//             rx_s==0 -> pulse frame_err; data_out unchanged; no ready_out. State -> BREAK.
//   BREAK     stay until rx_s==1, then -> IDLE. A held-low line never yields false frames.
//  Shift-register result is right-aligned: first received bit ends in data_out[0].
//  Latency: ready_out rises 1 clk after the mid-stop sample.
//   That is about 2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT clk after the rx falling edge.
//  Back-to-back frames: STOP->IDLE happens at mid-stop, so a start edge arriving half a bit later is caught.
//  Reset mid-frame: frame is aborted with no pulses; reception restarts on the next falling edge.
//  ready_out and frame_err are mutually exclusive; no pulse output is ever high for more than 1 clk.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - Frame becomes 8E1: one even-parity bit between the data bits and the stop bit.
//   - The PARITY state is active and parity_err is driven.
//  Undefined:
//   - 8N1 frame; the PARITY state and its logic are not generated.
//   - parity_err is tied to 0.
// TESTING (bench: CLOCK_RATE=160_000, BAUD_RATE=10_000 -> 16 clk/bit)
//  1. Frame 0x41, stop=1 -> data_out=0x41, ready_out high exactly 1 clk, frame_err=0.
//  2. Frames 0x30 then 0x39, no idle gap -> two ready pulses; data_out=0x30 then 0x39.
//  3. rx low for 5 clk, then high -> no pulses; FSM returns to IDLE.
//  4. Frame 0x55 with stop=0 -> frame_err 1 clk; data_out keeps its previous value.
//     Then rx held low for 48 clk, then a 0x0F frame -> single ready with 0x0F.
//  5. reset=0 for 3 clk during data bit 3 of a 0xA5 frame -> outputs 0, no pulses.
//     Next 0x5A frame -> data_out=0x5A with ready_out.
//  6. With UART_RX_PARITY_EN: 0x03 sent with parity bit 1 -> parity_err and ready_out pulse together.
//     0x03 with parity bit 0 -> ready_out only.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - mid-bit sampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN)
module uart_rx_sampler #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 ready_out,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic [1:0]           warm;
  logic                 armed;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 cnt_clr, cnt_run, shift_en, done_ok, done_bad;

  // Start detection is held off until the synchroniser has flushed its reset
  // value and the real line has been seen high, so a reset released while the
  // line is low (mid-frame) cannot launch a phantom frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      warm    <= 2'd0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (warm != 2'd2) warm <= warm + 2'd1;
      if (warm == 2'd2 && rx_s) armed <= 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

`ifdef UART_RX_PARITY_EN
  logic par_chk;
  logic par_bad;
`endif

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    cnt_run  = 1'b0;
    shift_en = 1'b0;
    done_ok  = 1'b0;
    done_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (armed && !rx_s) state_n = START;
      end
      START: begin
        cnt_run = 1'b1;
        if (cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_run = 1'b1;
        if (tick) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (idx == IDX_LAST) state_n = PARITY;
`else
          if (idx == IDX_LAST) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_run = 1'b1;
        if (tick) begin
          par_chk = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        cnt_run = 1'b1;
        if (tick) begin
          if (rx_s) begin
            done_ok = 1'b1;
            state_n = IDLE;
          end else begin
            done_bad = 1'b1;
            state_n  = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_run) cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (state != DATA) idx <= '0;
      else if (shift_en) idx <= idx + IDX_W'(1);
    end
  end

  // LSB arrives first and is shifted down, ending right-aligned in bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      data_out  <= '0;
      ready_out <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready_out <= done_ok;
      frame_err <= done_bad;
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (done_ok)  data_out <= shreg;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_chk) par_bad <= rx_s ^ (^shreg);
      parity_err <= done_ok & par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - directed self-checking bench for uart_rx_sampler (16 clk/bit)
module tb_uart_rx_sampler;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       ready_out, frame_err, parity_err;

  int tests = 0;
  int fails = 0;

  int rdy_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int overlap_cnt = 0, wide_cnt = 0, rp_both_cnt = 0;
  logic [7:0] rdy_log[$];
  logic prev_r = 1'b0, prev_f = 1'b0, prev_p = 1'b0;
  int lat;

  uart_rx_sampler #(
    .CLOCK_RATE(160_000),
    .BAUD_RATE (10_000),
    .DATA_BITS (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .ready_out (ready_out),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready_out) begin
      rdy_cnt++;
      rdy_log.push_back(data_out);
    end
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (ready_out && frame_err)  overlap_cnt++;
    if (ready_out && parity_err) rp_both_cnt++;
    if ((ready_out && prev_r) || (frame_err && prev_f) || (parity_err && prev_p)) wide_cnt++;
    prev_r = ready_out;
    prev_f = frame_err;
    prev_p = parity_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    if (rdy_log.size() > i) return rdy_log[i];
    return 8'hxx;
  endfunction

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold(par_ok ? ^d : ~^d, CPB);
`else
    if (par_ok) begin end
`endif
    hold(stop, CPB);
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data_out, 8'h00);
    check("reset_ready", ready_out, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_perr", parity_err, 1'b0);
    reset = 1'b1;
    hold(1'b1, 40);

    // 1: single frame and its latency from the start edge
    lat = 0;
    fork
      send_frame(8'h41, 1'b1, 1'b1);
      begin
        while (!ready_out && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
`ifdef UART_RX_PARITY_EN
    check("t1_latency", lat, 172);
`else
    check("t1_latency", lat, 156);
`endif
    check("t1_rdy_cnt", rdy_cnt, 1);
    check("t1_data", log_at(0), 8'h41);
    check("t1_ferr", ferr_cnt, 0);
    hold(1'b1, 2 * CPB);

    // 2: back-to-back frames, no idle gap
    send_frame(8'h30, 1'b1, 1'b1);
    send_frame(8'h39, 1'b1, 1'b1);
    check("t2_rdy_cnt", rdy_cnt, 3);
    check("t2_data0", log_at(1), 8'h30);
    check("t2_data1", log_at(2), 8'h39);
    hold(1'b1, 2 * CPB);

    // 3: short glitch rejected
    hold(1'b0, 5);
    hold(1'b1, 3 * CPB);
    check("t3_rdy_cnt", rdy_cnt, 3);
    check("t3_ferr", ferr_cnt, 0);

    // 4: bad stop bit, held-low line, then recovery
    send_frame(8'h55, 1'b1, 1'b0);
    check("t4_ferr", ferr_cnt, 1);
    check("t4_rdy_cnt", rdy_cnt, 3);
    check("t4_data_kept", data_out, 8'h39);
    hold(1'b0, 48);
    hold(1'b1, 2 * CPB);
    check("t4_break_ferr", ferr_cnt, 1);
    check("t4_break_rdy", rdy_cnt, 3);
    send_frame(8'h0F, 1'b1, 1'b1);
    check("t4_rdy_cnt2", rdy_cnt, 4);
    check("t4_data2", log_at(3), 8'h0F);
    hold(1'b1, 2 * CPB);

    // 5: reset during data bit 3 of 0xA5 (bits LSB first: 1,0,1,0,...)
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, 5);
    reset = 1'b0;
    hold(1'b0, 2);
    check("t5_rst_data", data_out, 8'h00);
    check("t5_rst_ready", ready_out, 1'b0);
    hold(1'b0, 1);
    reset = 1'b1;
    hold(1'b0, 8);
    hold(1'b1, 4 * CPB);
    check("t5_no_rdy", rdy_cnt, 4);
    check("t5_no_ferr", ferr_cnt, 1);
    check("t5_data_zero", data_out, 8'h00);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("t5_rdy_cnt", rdy_cnt, 5);
    check("t5_data", log_at(4), 8'h5A);
    check("t5_data_out", data_out, 8'h5A);
    hold(1'b1, 2 * CPB);

`ifdef UART_RX_PARITY_EN
    // 6: 0x03 has even parity 0; a 1 on the line is a mismatch
    send_frame(8'h03, 1'b0, 1'b1);
    check("t6_perr", perr_cnt, 1);
    check("t6_both", rp_both_cnt, 1);
    check("t6_rdy_cnt", rdy_cnt, 6);
    check("t6_data", log_at(5), 8'h03);
    hold(1'b1, 2 * CPB);
    send_frame(8'h03, 1'b1, 1'b1);
    check("t6_perr_ok", perr_cnt, 1);
    check("t6_rdy_cnt2", rdy_cnt, 7);
    hold(1'b1, 2 * CPB);
`else
    check("perr_tied", perr_cnt, 0);
`endif

    check("excl_rdy_ferr", overlap_cnt, 0);
    check("pulse_width", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
